// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin arbiter and controller for one shared 8-bit add/subtract unit
module addsub_arbiter #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req0_add,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic       req1_add,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_sum,
    output logic       rsp_cout,
    output logic       rsp_v,
    output logic [7:0] adder_a,
    output logic [7:0] adder_b,
    output logic       adder_add,
    input  logic [7:0] adder_sum,
    input  logic       adder_cout,
    input  logic       adder_v,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
    state_t     state;
    logic       ptr;
    logic [3:0] cnt;
    logic       win;
    assign win        = (req0_valid && req1_valid) ? ptr : req1_valid;
    assign req0_ready = rst_n && state == IDLE && req0_valid && !win;
    assign req1_ready = rst_n && state == IDLE && req1_valid && win;
    assign busy       = state != IDLE;
    // grant, settle countdown and response capture; reset discards any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            cnt       <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_sum   <= 8'h00;
            rsp_cout  <= 1'b0;
            rsp_v     <= 1'b0;
            adder_a   <= 8'h00;
            adder_b   <= 8'h00;
            adder_add <= 1'b1;
        end else begin
            case (state)
                IDLE: if (req0_ready || req1_ready) begin
                    adder_a   <= win ? req1_a : req0_a;
                    adder_b   <= win ? req1_b : req0_b;
                    adder_add <= win ? req1_add : req0_add;
                    rsp_id    <= win;
                    ptr       <= !win;
                    cnt       <= 4'(SETTLE_CYCLES - 1);
                    state     <= SETTLE;
                end
                SETTLE: if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    rsp_sum   <= adder_sum;
                    rsp_cout  <= adder_cout;
                    rsp_v     <= adder_v;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: directed and randomized checks of arbitration, settle timing and response handshake
module tb_addsub_arbiter;
    localparam int S = 2;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req0_add;
    logic [7:0] req0_a, req0_b;
    logic       req1_valid, req1_ready, req1_add;
    logic [7:0] req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_v;
    logic [7:0] rsp_sum;
    logic [7:0] adder_a, adder_b, adder_sum;
    logic       adder_add, adder_cout, adder_v, busy;
    int         total = 0;
    int         bad = 0;
    logic       ptr_m = 1'b0;
    logic       last_id;
    logic [9:0] last_r;
    logic [3:0] seq;
    int         age = 0;
    logic [16:0] last_ops = '0;
    logic [9:0] true_r;

    always #5 clk = ~clk;

    addsub_arbiter #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_add(req0_add),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_add(req1_add),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .rsp_cout(rsp_cout), .rsp_v(rsp_v),
        .adder_a(adder_a), .adder_b(adder_b), .adder_add(adder_add),
        .adder_sum(adder_sum), .adder_cout(adder_cout), .adder_v(adder_v), .busy(busy)
    );

    function automatic logic [9:0] ref_op(input logic [7:0] a, input logic [7:0] b, input logic add);
        logic [8:0] s;
        logic       v;
        s = add ? {1'b0, a} + {1'b0, b} : {1'b0, a} + {1'b0, ~b} + 9'd1;
        v = add ? (a[7] == b[7] && s[7] != a[7]) : (a[7] != b[7] && s[7] != a[7]);
        return {s[8], v, s[7:0]};
    endfunction

    // shared adder stand-in: outputs are corrupted until operands have been stable for S-1 edges
    always @(negedge clk) begin
        if ({adder_a, adder_b, adder_add} != last_ops) begin
            last_ops <= {adder_a, adder_b, adder_add};
            age <= 0;
        end else if (age < 15) begin
            age <= age + 1;
        end
    end
    assign true_r = ref_op(adder_a, adder_b, adder_add);
    assign {adder_cout, adder_v, adder_sum} = (age >= S - 1) ? true_r : ~true_r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rnd_ops(input logic x);
        if (x) begin
            req1_a = 8'($urandom); req1_b = 8'($urandom); req1_add = 1'($urandom);
        end else begin
            req0_a = 8'($urandom); req0_b = 8'($urandom); req0_add = 1'($urandom);
        end
    endtask

    task automatic serve(input bit keep, input int hold);
        logic       w;
        logic [9:0] e;
        logic [7:0] ga;
        int         lat;
        rsp_ready = (hold == 0);
        #1;
        w = (req0_valid && req1_valid) ? ptr_m : req1_valid;
        chk("grant_ready0", req0_ready, !w);
        chk("grant_ready1", req1_ready, w);
        e  = w ? ref_op(req1_a, req1_b, req1_add) : ref_op(req0_a, req0_b, req0_add);
        ga = w ? req1_a : req0_a;
        @(posedge clk);
        ptr_m = !w;
        #1;
        if (keep) rnd_ops(w);
        else if (w) req1_valid = 1'b0;
        else req0_valid = 1'b0;
        lat = -1;
        do begin
            @(negedge clk);
            lat++;
            chk("adder_a_hold", adder_a, ga);
            chk("busy_inflight", busy, 1'b1);
            chk("ready_inflight", {req0_ready, req1_ready}, 2'b00);
            if (!req0_valid) req0_a = 8'($urandom);
        end while (!rsp_valid && lat < 20);
        chk("latency", lat, S);
        chk("rsp_id", rsp_id, w);
        chk("rsp_sum", rsp_sum, e[7:0]);
        chk("rsp_flags", {rsp_cout, rsp_v}, e[9:8]);
        last_id = rsp_id;
        last_r  = {rsp_cout, rsp_v, rsp_sum};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_stable", {rsp_valid, rsp_id, rsp_cout, rsp_v, rsp_sum}, {1'b1, w, e[9], e[8], e[7:0]});
            chk("bp_ready", {req0_ready, req1_ready}, 2'b00);
            chk("bp_busy", busy, 1'b1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rsp_accepted", rsp_valid, 1'b0);
        chk("idle_busy", busy, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h00; req0_b = 8'h00; req0_add = 1'b0;
        req1_valid = 1'b1; req1_a = 8'h00; req1_b = 8'h00; req1_add = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {req0_ready, req1_ready}, 2'b00);
        chk("rst_rsp", {rsp_valid, rsp_id, rsp_cout, rsp_v, rsp_sum}, 12'h000);
        chk("rst_adder", {adder_a, adder_b, adder_add}, {8'h00, 8'h00, 1'b1});
        chk("rst_busy", busy, 1'b0);
        req0_valid = 1'b0; req1_valid = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        // single request
        req0_valid = 1'b1; req0_a = 8'h25; req0_b = 8'h13; req0_add = 1'b1;
        serve(0, 0);
        chk("single_result", last_r, {1'b0, 1'b0, 8'h38});
        chk("single_id", last_id, 1'b0);
        // tie after reset
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; ptr_m = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h7F; req0_b = 8'h01; req0_add = 1'b1;
        req1_valid = 1'b1; req1_a = 8'h10; req1_b = 8'h20; req1_add = 1'b0;
        serve(0, 0);
        chk("tie1_id", last_id, 1'b0);
        chk("tie1_result", last_r, {1'b0, 1'b1, 8'h80});
        serve(0, 0);
        chk("tie2_id", last_id, 1'b1);
        chk("tie2_sum", last_r[7:0], 8'hF0);
        // fairness with both held valid
        rnd_ops(0); rnd_ops(1); req0_valid = 1'b1; req1_valid = 1'b1; seq = 4'b0;
        for (int i = 0; i < 4; i++) begin
            serve(1, 0);
            seq = {seq[2:0], last_id};
        end
        chk("fair_seq", seq, 4'b0101);
        req0_valid = 1'b0; req1_valid = 1'b0;
        // backpressure
        rnd_ops(1); req1_valid = 1'b1;
        serve(0, 5);
        // reset mid-SETTLE discards the operation and clears the pointer
        rnd_ops(0); rnd_ops(1); req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_adder_a", adder_a, 8'h00);
        chk("mid_rst_ready", {req0_ready, req1_ready}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1; ptr_m = 1'b0;
        serve(0, 0);
        chk("post_rst_tie_id", last_id, 1'b0);
        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            if (!req0_valid && $urandom_range(0, 1) == 1) begin rnd_ops(0); req0_valid = 1'b1; end
            if (!req1_valid && $urandom_range(0, 1) == 1) begin rnd_ops(1); req1_valid = 1'b1; end
            if (!req0_valid && !req1_valid) begin rnd_ops(0); req0_valid = 1'b1; end
            serve(1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
